// File: rtl/overlay_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// overlay_scheduler_pkg
// Shared definitions for the text-overlay scheduler: cell-grid constants,
// mode encodings, FSM state codes and small mode-decoding helpers.
// -----------------------------------------------------------------------------
package overlay_scheduler_pkg;

   // Cell grid (8x8-pixel cells)
   localparam int COLS  = 80;   // screen width in cells
   localparam int ROWS  = 60;   // screen height in cells
   localparam int OVL_W = 23;   // overlay width in cells
   localparam int OVL_H = 9;    // overlay height in cells

   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_BOUNCE = 2'b01,
      MODE_BLINK  = 2'b10,
      MODE_BOTH   = 2'b11
   } mode_e;

   typedef enum logic {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic has_bounce(input logic [1:0] m);
      return (m == MODE_BOUNCE) || (m == MODE_BOTH);
   endfunction

   function automatic logic has_blink(input logic [1:0] m);
      return (m == MODE_BLINK) || (m == MODE_BOTH);
   endfunction

endpackage

// File: rtl/overlay_scheduler_bounce_axis.sv
// -----------------------------------------------------------------------------
// bounce_axis
// Next-position logic for one axis of the bouncing overlay. Purely
// combinational; the top module owns the registers.
//   step    : advance this axis by one cell this update
//   pos     : current origin coordinate (0..MAX)
//   dir     : current direction, 1 = +1, 0 = -1
//   pos_nxt : coordinate after the update
//   dir_nxt : direction after the update
//   flip    : direction was reversed at an edge on this update
// -----------------------------------------------------------------------------
module bounce_axis #(
   parameter int W   = 7,
   parameter int MAX = 57
) (
   input  logic         step,
   input  logic [W-1:0] pos,
   input  logic         dir,
   output logic [W-1:0] pos_nxt,
   output logic         dir_nxt,
   output logic         flip
);

   always_comb begin
      pos_nxt = pos;
      dir_nxt = dir;
      flip    = 1'b0;
      if (step) begin
         if (dir) begin
            // At the far edge: reflect and move back one cell in the same update
            if (pos == W'(MAX)) begin
               pos_nxt = pos - W'(1);
               dir_nxt = 1'b0;
               flip    = 1'b1;
            end else begin
               pos_nxt = pos + W'(1);
            end
         end else begin
            if (pos == '0) begin
               pos_nxt = W'(1);
               dir_nxt = 1'b1;
               flip    = 1'b1;
            end else begin
               pos_nxt = pos - W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/overlay_scheduler.sv
// -----------------------------------------------------------------------------
// overlay_scheduler
// Once-per-frame scheduler for the VGA text overlay. Advances during vertical
// blanking on the frame tick (x==0, y==TICK_Y): holds at the start position
// for HOLD_FRAMES, then bounces and/or blinks according to mode.
//   clk, rst_n   : pixel clock, async active-low reset
//   ena, pause   : frame is skipped when ena=0 or pause=1
//   x, y         : current pixel column / row
//   mode         : 00 static, 01 bounce, 10 blink, 11 bounce+blink
//   org_x, org_y : overlay origin in cells
//   visible      : overlay enable for the renderer
//   color        : palette index, +1 on every edge bounce
//   hit          : one-clk pulse after an update that bounced
// -----------------------------------------------------------------------------
module overlay_scheduler
   import overlay_scheduler_pkg::*;
#(
   parameter int COLS_P       = COLS,
   parameter int ROWS_P       = ROWS,
   parameter int OVL_W_P      = OVL_W,
   parameter int OVL_H_P      = OVL_H,
   parameter int INIT_X       = 30,
   parameter int INIT_Y       = 25,
   parameter int HOLD_FRAMES  = 60,
   parameter int STEP_FRAMES  = 2,
   parameter int BLINK_FRAMES = 30,
   parameter int TICK_Y       = 480
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic [1:0] mode,
   input  logic       pause,
   output logic [6:0] org_x,
   output logic [5:0] org_y,
   output logic       visible,
   output logic [2:0] color,
   output logic       hit
);

   localparam int MAX_X = COLS_P - OVL_W_P;
   localparam int MAX_Y = ROWS_P - OVL_H_P;
   localparam int HW    = $clog2(HOLD_FRAMES + 1);
   localparam int SW    = $clog2(STEP_FRAMES + 1);
   localparam int BW    = $clog2(BLINK_FRAMES + 1);

   state_e          state_q,     state_d;
   logic [HW-1:0]   hold_cnt_q,  hold_cnt_d;
   logic [SW-1:0]   step_cnt_q,  step_cnt_d;
   logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
   logic [6:0]      org_x_q,     org_x_d;
   logic [5:0]      org_y_q,     org_y_d;
   logic            dir_x_q,     dir_x_d;
   logic            dir_y_q,     dir_y_d;
   logic            visible_q,   visible_d;
   logic [2:0]      color_q,     color_d;
   logic            hit_q,       hit_d;

   logic            tick;
   logic            adv;
   logic            step_now;
   logic [6:0]      pos_x_nxt;
   logic [5:0]      pos_y_nxt;
   logic            dir_x_nxt, dir_y_nxt;
   logic            flip_x, flip_y;

   assign tick = (x == 10'd0) && (y == 10'(TICK_Y));
   assign adv  = tick && ena && !pause;

   // Both axes move together on the last tick of each step period
   assign step_now = adv && (state_q == ST_RUN) && has_bounce(mode) &&
                     (step_cnt_q == SW'(STEP_FRAMES - 1));

   bounce_axis #(.W(7), .MAX(MAX_X)) u_axis_x (
      .step    (step_now),
      .pos     (org_x_q),
      .dir     (dir_x_q),
      .pos_nxt (pos_x_nxt),
      .dir_nxt (dir_x_nxt),
      .flip    (flip_x)
   );

   bounce_axis #(.W(6), .MAX(MAX_Y)) u_axis_y (
      .step    (step_now),
      .pos     (org_y_q),
      .dir     (dir_y_q),
      .pos_nxt (pos_y_nxt),
      .dir_nxt (dir_y_nxt),
      .flip    (flip_y)
   );

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      step_cnt_d  = step_cnt_q;
      blink_cnt_d = blink_cnt_q;
      org_x_d     = org_x_q;
      org_y_d     = org_y_q;
      dir_x_d     = dir_x_q;
      dir_y_d     = dir_y_q;
      visible_d   = visible_q;
      color_d     = color_q;
      hit_d       = 1'b0;

      if (adv) begin
         case (state_q)
            ST_HOLD: begin
               visible_d = 1'b1;
               if (hold_cnt_q == HW'(HOLD_FRAMES - 1)) begin
                  state_d     = ST_RUN;
                  hold_cnt_d  = '0;
                  step_cnt_d  = '0;
                  blink_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + HW'(1);
               end
            end
            ST_RUN: begin
               if (has_bounce(mode)) begin
                  if (step_now) begin
                     step_cnt_d = '0;
                     org_x_d    = pos_x_nxt;
                     org_y_d    = pos_y_nxt;
                     dir_x_d    = dir_x_nxt;
                     dir_y_d    = dir_y_nxt;
                     // A corner flips both axes but counts as a single hit
                     if (flip_x || flip_y) begin
                        hit_d   = 1'b1;
                        color_d = color_q + 3'd1;
                     end
                  end else begin
                     step_cnt_d = step_cnt_q + SW'(1);
                  end
               end
               if (has_blink(mode)) begin
                  if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                     blink_cnt_d = '0;
                     visible_d   = !visible_q;
                  end else begin
                     blink_cnt_d = blink_cnt_q + BW'(1);
                  end
               end else begin
                  visible_d   = 1'b1;
                  blink_cnt_d = '0;
               end
            end
            default: state_d = ST_HOLD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_HOLD;
         hold_cnt_q  <= '0;
         step_cnt_q  <= '0;
         blink_cnt_q <= '0;
         org_x_q     <= 7'(INIT_X);
         org_y_q     <= 6'(INIT_Y);
         dir_x_q     <= 1'b1;
         dir_y_q     <= 1'b1;
         visible_q   <= 1'b1;
         color_q     <= 3'd0;
         hit_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         step_cnt_q  <= step_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         org_x_q     <= org_x_d;
         org_y_q     <= org_y_d;
         dir_x_q     <= dir_x_d;
         dir_y_q     <= dir_y_d;
         visible_q   <= visible_d;
         color_q     <= color_d;
         hit_q       <= hit_d;
      end
   end

   assign org_x   = org_x_q;
   assign org_y   = org_y_q;
   assign visible = visible_q;
   assign color   = color_q;
   assign hit     = hit_q;

endmodule

// File: tb/tb_overlay_scheduler.sv
// -----------------------------------------------------------------------------
// tb_overlay_scheduler
// Two scheduler instances share one stimulus stream: instance 0 uses the
// default VGA geometry, instance 1 a tiny 5x5 position range with short
// periods so that corner bounces occur often. A frame-level model tracks
// each instance and is compared against the DUT outputs on every cycle.
// -----------------------------------------------------------------------------
module tb_overlay_scheduler;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       ena;
   logic       pause;
   logic [9:0] x;
   logic [9:0] y;
   logic [1:0] mode;

   logic [6:0] org_x   [2];
   logic [5:0] org_y   [2];
   logic       visible [2];
   logic [2:0] color   [2];
   logic       hit     [2];

   overlay_scheduler u_dut0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .x       (x),
      .y       (y),
      .mode    (mode),
      .pause   (pause),
      .org_x   (org_x[0]),
      .org_y   (org_y[0]),
      .visible (visible[0]),
      .color   (color[0]),
      .hit     (hit[0])
   );

   overlay_scheduler #(
      .COLS_P       (27),
      .ROWS_P       (13),
      .INIT_X       (2),
      .INIT_Y       (2),
      .HOLD_FRAMES  (3),
      .STEP_FRAMES  (1),
      .BLINK_FRAMES (3)
   ) u_dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .x       (x),
      .y       (y),
      .mode    (mode),
      .pause   (pause),
      .org_x   (org_x[1]),
      .org_y   (org_y[1]),
      .visible (visible[1]),
      .color   (color[1]),
      .hit     (hit[1])
   );

   // ---------------- model parameters per instance ----------------
   int p_mx [2] = '{57, 4};
   int p_my [2] = '{51, 4};
   int p_ix [2] = '{30, 2};
   int p_iy [2] = '{25, 2};
   int p_h  [2] = '{60, 3};
   int p_s  [2] = '{2, 1};
   int p_b  [2] = '{30, 3};

   // ---------------- frame-level model ----------------
   int m_x [2], m_y [2], m_dx [2], m_dy [2];
   int m_hold [2], m_step [2], m_blink [2], m_col [2];
   bit m_run [2], m_vis [2], m_hit [2];

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   function automatic void check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_x[i] = p_ix[i];  m_y[i] = p_iy[i];
         m_dx[i] = 1;       m_dy[i] = 1;
         m_hold[i] = 0;     m_step[i] = 0;   m_blink[i] = 0;
         m_col[i] = 0;      m_run[i] = 1'b0;
         m_vis[i] = 1'b1;   m_hit[i] = 1'b0;
      end
   endtask

   // One clock edge of the model: only a qualifying frame tick changes anything
   task automatic model_edge(input bit frame_adv, input logic [1:0] m);
      int nx, ny;
      bit fx, fy;
      for (int i = 0; i < 2; i++) begin
         m_hit[i] = 1'b0;
         if (!frame_adv) continue;
         if (!m_run[i]) begin
            m_vis[i] = 1'b1;
            m_hold[i]++;
            if (m_hold[i] == p_h[i]) begin
               m_run[i] = 1'b1;
               m_hold[i] = 0; m_step[i] = 0; m_blink[i] = 0;
            end
         end else begin
            if (m[0]) begin
               m_step[i]++;
               if (m_step[i] == p_s[i]) begin
                  m_step[i] = 0;
                  fx = 1'b0; fy = 1'b0;
                  nx = m_x[i] + m_dx[i];
                  if (nx < 0 || nx > p_mx[i]) begin
                     m_dx[i] = -m_dx[i];
                     nx = m_x[i] + m_dx[i];
                     fx = 1'b1;
                  end
                  ny = m_y[i] + m_dy[i];
                  if (ny < 0 || ny > p_my[i]) begin
                     m_dy[i] = -m_dy[i];
                     ny = m_y[i] + m_dy[i];
                     fy = 1'b1;
                  end
                  m_x[i] = nx; m_y[i] = ny;
                  if (fx || fy) begin
                     m_hit[i] = 1'b1;
                     m_col[i] = (m_col[i] + 1) % 8;
                  end
               end
            end
            if (m[1]) begin
               m_blink[i]++;
               if (m_blink[i] == p_b[i]) begin
                  m_blink[i] = 0;
                  m_vis[i] = !m_vis[i];
               end
            end else begin
               m_vis[i] = 1'b1;
               m_blink[i] = 0;
            end
         end
      end
   endtask

   // ---------------- compare process ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
               check($sformatf("org_x[%0d]", i),   int'(org_x[i]),   m_x[i]);
               check($sformatf("org_y[%0d]", i),   int'(org_y[i]),   m_y[i]);
               check($sformatf("visible[%0d]", i), int'(visible[i]), int'(m_vis[i]));
               check($sformatf("color[%0d]", i),   int'(color[i]),   m_col[i]);
               check($sformatf("hit[%0d]", i),     int'(hit[i]),     int'(m_hit[i]));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at negedge+2; drives one cycle and returns at the next negedge+2
   task automatic cycle(input bit t, input bit e, input bit p, input logic [1:0] m);
      if (t) begin
         x = 10'd0; y = 10'd480;
      end else begin
         case ($urandom_range(0, 2))
            0: begin x = 10'd0; y = 10'($urandom_range(0, 479)); end
            1: begin x = 10'($urandom_range(1, 799)); y = 10'd480; end
            default: begin
               x = 10'($urandom_range(1, 799));
               y = 10'($urandom_range(0, 524));
            end
         endcase
      end
      ena = e; pause = p; mode = m;
      @(posedge clk);
      if (rst_n) model_edge(t && e && !p, m);
      @(negedge clk);
      #2;
   endtask

   // One tick cycle followed by a few non-tick cycles with junk controls,
   // which must not disturb anything
   task automatic frame(input bit e, input bit p, input logic [1:0] m);
      cycle(1'b1, e, p, m);
      repeat ($urandom_range(1, 2))
         cycle(1'b0, 1'($urandom), 1'($urandom), 2'($urandom));
   endtask

   task automatic check_org0(input string tag, input int ex, input int ey);
      check({tag, "_org_x"}, int'(org_x[0]), ex);
      check({tag, "_org_y"}, int'(org_y[0]), ey);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0; ena = 1'b1; pause = 1'b0; mode = 2'b00;
      x = 10'd1; y = 10'd0;
      model_reset();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      check_org0("rst", 30, 25);
      check("rst_visible", int'(visible[0]), 1);
      check("rst_color",   int'(color[0]),   0);
      check("rst_hit",     int'(hit[0]),     0);
      chk_en = 1'b1;

      // HOLD: 59 ticks leave the overlay untouched even in bounce mode
      repeat (59) frame(1'b1, 1'b0, 2'b01);
      check_org0("hold59", 30, 25);
      check("hold59_visible", int'(visible[0]), 1);
      frame(1'b1, 1'b0, 2'b01);
      check_org0("hold60", 30, 25);
      repeat (2) frame(1'b1, 1'b0, 2'b01);
      check_org0("first_step", 31, 26);

      // 27 steps total: y reflects at 51 -> 50, x reaches 57
      repeat (52) frame(1'b1, 1'b0, 2'b01);
      check_org0("y_bounce", 57, 50);
      check("y_bounce_color", int'(color[0]), 1);
      repeat (2) frame(1'b1, 1'b0, 2'b01);
      check_org0("x_bounce", 56, 49);
      check("x_bounce_color", int'(color[0]), 2);

      // Blink: toggles on the 30th tick, static mode forces visible again
      repeat (29) frame(1'b1, 1'b0, 2'b10);
      check("blink29_visible", int'(visible[0]), 1);
      frame(1'b1, 1'b0, 2'b10);
      check("blink30_visible", int'(visible[0]), 0);
      frame(1'b1, 1'b0, 2'b00);
      check("static_visible", int'(visible[0]), 1);
      check_org0("static", 56, 49);

      // Paused ticks are skipped entirely
      repeat (10) frame(1'b1, 1'b1, 2'b11);
      check_org0("pause", 56, 49);
      check("pause_color", int'(color[0]), 2);

      // Randomised operation
      repeat (500)
         frame(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), 2'($urandom));

      // Asynchronous reset between clock edges
      cycle(1'b0, 1'b1, 1'b0, 2'b11);
      #1 rst_n = 1'b0;
      #1;
      check_org0("async_rst", 30, 25);
      check("async_rst_visible", int'(visible[0]), 1);
      check("async_rst_hit",     int'(hit[0]),     0);
      check("async_rst_color",   int'(color[0]),   0);
      model_reset();
      @(negedge clk);
      #2;
      cycle(1'b1, 1'b1, 1'b0, 2'b01);
      rst_n = 1'b1;

      repeat (59) frame(1'b1, 1'b0, 2'b01);
      check_org0("rehold59", 30, 25);
      repeat (3) frame(1'b1, 1'b0, 2'b01);
      check_org0("restep", 31, 26);

      repeat (100)
         frame(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), 2'($urandom));

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
